// File: rtl/kbd_mouse_bridge.sv
// kbd_mouse_bridge: brings user_io keyboard/mouse events into the clk domain.
// Keycodes are queued in a small circular FIFO that the consumer drains with a
// valid/ack handshake. Mouse deltas are accumulated into free-running 8-bit
// position counters that wrap modulo 256.
module kbd_mouse_bridge #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       _rst,
    input  logic [7:0] kbd_mouse_data,
    input  logic [1:0] kbd_mouse_type,
    input  logic       kbd_mouse_strobe,
    input  logic [2:0] mouse_buttons,
    input  logic       kbd_ack,
    input  logic       ovf_clr,
    output logic [7:0] kbd_data,
    output logic       kbd_valid,
    output logic [7:0] mouse_x,
    output logic [7:0] mouse_y,
    output logic [2:0] mouse_btn,
    output logic       fifo_full,
    output logic       kbd_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] TYPE_MOUSE_X = 2'b00;
    localparam logic [1:0] TYPE_MOUSE_Y = 2'b01;
    localparam logic [1:0] TYPE_KEYCODE = 2'b10;

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic          strb_meta_r;
    logic          strb_sync_r;
    logic          strb_prev_r;
    logic          primed_r;
    logic [1:0]    prime_cnt_r;
    logic [2:0]    btn_meta_r;
    logic [2:0]    mouse_btn_r;
    logic [7:0]    mouse_x_r;
    logic [7:0]    mouse_y_r;
    logic [7:0]    kbd_data_r;
    logic          kbd_valid_r;
    logic          fifo_full_r;
    logic          kbd_ovf_r;
    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;

    logic          evt_s;
    logic          push_req_s;
    logic          push_s;
    logic          pop_s;
    logic          ovf_set_s;
    logic [AW:0]   wr_ptr_nx_s;
    logic [AW:0]   rd_ptr_nx_s;
    logic          empty_nx_s;
    logic          full_nx_s;
    logic [7:0]    head_nx_s;

    assign kbd_data  = kbd_data_r;
    assign kbd_valid = kbd_valid_r;
    assign mouse_x   = mouse_x_r;
    assign mouse_y   = mouse_y_r;
    assign mouse_btn = mouse_btn_r;
    assign fifo_full = fifo_full_r;
    assign kbd_ovf   = kbd_ovf_r;

    // Strobe synchronizer, edge-detect history, and post-reset priming counter.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            strb_meta_r <= 1'b0;
            strb_sync_r <= 1'b0;
            strb_prev_r <= 1'b0;
            prime_cnt_r <= 2'd0;
            primed_r    <= 1'b0;
        end else begin
            strb_meta_r <= kbd_mouse_strobe;
            strb_sync_r <= strb_meta_r;
            strb_prev_r <= strb_sync_r;
            if (!primed_r) begin
                prime_cnt_r <= prime_cnt_r + 2'd1;
                primed_r    <= (prime_cnt_r == 2'd2);
            end
        end
    end

    // Button synchronizer, two flops per bit.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            btn_meta_r  <= 3'b000;
            mouse_btn_r <= 3'b000;
        end else begin
            btn_meta_r  <= mouse_buttons;
            mouse_btn_r <= btn_meta_r;
        end
    end

    // Event decode, FIFO push/pop arbitration and next-state of the queue flags.
    always_comb begin
        evt_s       = strb_sync_r & ~strb_prev_r & primed_r;
        push_req_s  = evt_s & (kbd_mouse_type == TYPE_KEYCODE);
        pop_s       = kbd_valid_r & kbd_ack;
        push_s      = push_req_s & (~fifo_full_r | pop_s);
        ovf_set_s   = push_req_s & fifo_full_r & ~pop_s;
        wr_ptr_nx_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        rd_ptr_nx_s = pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        empty_nx_s  = (wr_ptr_nx_s == rd_ptr_nx_s);
        full_nx_s   = (wr_ptr_nx_s[AW-1:0] == rd_ptr_nx_s[AW-1:0]) &&
                      (wr_ptr_nx_s[AW] != rd_ptr_nx_s[AW]);
        // The entry being written this cycle is not in mem_r yet, so forward it
        // when it becomes the head.
        if (empty_nx_s) begin
            head_nx_s = 8'h00;
        end else if (push_s && (rd_ptr_nx_s[AW-1:0] == wr_ptr_r[AW-1:0])) begin
            head_nx_s = kbd_mouse_data;
        end else begin
            head_nx_s = mem_r[rd_ptr_nx_s[AW-1:0]];
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= kbd_mouse_data;
        end
    end

    // FIFO pointers, registered head/flags and the sticky overflow flag.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            kbd_data_r  <= 8'h00;
            kbd_valid_r <= 1'b0;
            fifo_full_r <= 1'b0;
            kbd_ovf_r   <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nx_s;
            rd_ptr_r    <= rd_ptr_nx_s;
            kbd_data_r  <= head_nx_s;
            kbd_valid_r <= ~empty_nx_s;
            fifo_full_r <= full_nx_s;
            kbd_ovf_r   <= ovf_set_s | (kbd_ovf_r & ~ovf_clr);
        end
    end

    // Mouse position counters; 8-bit add wraps and treats data as two's complement.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            mouse_x_r <= 8'h00;
            mouse_y_r <= 8'h00;
        end else if (evt_s) begin
            case (kbd_mouse_type)
                TYPE_MOUSE_X: mouse_x_r <= mouse_x_r + kbd_mouse_data;
                TYPE_MOUSE_Y: mouse_y_r <= mouse_y_r + kbd_mouse_data;
                default: begin
                    mouse_x_r <= mouse_x_r;
                    mouse_y_r <= mouse_y_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kbd_mouse_bridge.sv
// Self-checking bench for kbd_mouse_bridge against a queue-based event model.
`timescale 1ns/1ps
module tb_kbd_mouse_bridge;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] kbd_mouse_data = 8'h00;
    logic [1:0] kbd_mouse_type = 2'b11;
    logic       kbd_mouse_strobe = 1'b0;
    logic [2:0] mouse_buttons = 3'b000;
    logic       kbd_ack = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] kbd_data;
    logic       kbd_valid;
    logic [7:0] mouse_x;
    logic [7:0] mouse_y;
    logic [2:0] mouse_btn;
    logic       fifo_full;
    logic       kbd_ovf;

    int errors = 0;
    int checks = 0;

    // Reference model: positions, keycode queue, sticky overflow.
    logic [7:0] m_x;
    logic [7:0] m_y;
    logic [7:0] m_q[$];
    logic       m_ovf;

    kbd_mouse_bridge #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), ._rst(rst_n),
        .kbd_mouse_data(kbd_mouse_data), .kbd_mouse_type(kbd_mouse_type),
        .kbd_mouse_strobe(kbd_mouse_strobe), .mouse_buttons(mouse_buttons),
        .kbd_ack(kbd_ack), .ovf_clr(ovf_clr),
        .kbd_data(kbd_data), .kbd_valid(kbd_valid),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_btn(mouse_btn),
        .fifo_full(fifo_full), .kbd_ovf(kbd_ovf)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_x = 8'h00; m_y = 8'h00; m_ovf = 1'b0; m_q.delete();
    endtask

    task automatic model_event(input logic [1:0] t, input logic [7:0] d);
        case (t)
            2'b00: m_x = m_x + d;
            2'b01: m_y = m_y + d;
            2'b10: begin
                if (m_q.size() < DEPTH) m_q.push_back(d);
                else m_ovf = 1'b1;
            end
            default: ;
        endcase
    endtask

    // One strobe event: 4 cycles high, 3 cycles low, then model update.
    task automatic do_strobe(input logic [1:0] t, input logic [7:0] d);
        @(negedge clk);
        kbd_mouse_type = t; kbd_mouse_data = d; kbd_mouse_strobe = 1'b1;
        repeat (4) @(negedge clk);
        kbd_mouse_strobe = 1'b0;
        repeat (3) @(negedge clk);
        model_event(t, d);
    endtask

    task automatic do_ack();
        @(negedge clk); kbd_ack = 1'b1;
        @(negedge clk); kbd_ack = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
    endtask

    task automatic do_ovf_clr();
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({kbd_data, kbd_valid, mouse_x, mouse_y, mouse_btn, fifo_full, kbd_ovf} !== 30'd0) begin
            errors++;
            $display("FAIL reset_state: got data=%h valid=%b x=%h y=%h btn=%b full=%b ovf=%b want all 0",
                     kbd_data, kbd_valid, mouse_x, mouse_y, mouse_btn, fifo_full, kbd_ovf);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_mouse_x();
        logic [7:0] exp_x [2];
        logic [7:0] dat [2];
        dat[0] = 8'h05; dat[1] = 8'hFE;
        exp_x[0] = 8'h05; exp_x[1] = 8'h03;
        for (int i = 0; i < 2; i++) begin
            do_strobe(2'b00, dat[i]);
            checks++;
            if (mouse_x !== exp_x[i] || mouse_x !== m_x) begin
                errors++;
                $display("FAIL mouse_x_%0d: got %h want %h", i, mouse_x, exp_x[i]);
            end
            checks++;
            if (mouse_y !== 8'h00 || kbd_valid !== 1'b0) begin
                errors++;
                $display("FAIL mouse_x_side_%0d: got y=%h valid=%b want y=00 valid=0", i, mouse_y, kbd_valid);
            end
        end
    endtask

    task automatic test_mouse_y_wrap();
        do_strobe(2'b01, 8'h7F);
        do_strobe(2'b01, 8'h02);
        checks++;
        if (mouse_y !== 8'h81) begin
            errors++;
            $display("FAIL mouse_y_wrap: got %h want 81", mouse_y);
        end
        for (int i = 0; i < 3; i++) do_strobe(2'b01, 8'h80);
        checks++;
        if (mouse_y !== 8'h01 || mouse_y !== m_y) begin
            errors++;
            $display("FAIL mouse_y_wrap3: got %h want 01", mouse_y);
        end
    endtask

    task automatic test_fifo_order();
        logic [7:0] keys [3];
        keys[0] = 8'h45; keys[1] = 8'h12; keys[2] = 8'h63;
        for (int i = 0; i < 3; i++) do_strobe(2'b10, keys[i]);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (kbd_valid !== 1'b1 || kbd_data !== keys[i]) begin
                errors++;
                $display("FAIL fifo_order_%0d: got valid=%b data=%h want valid=1 data=%h",
                         i, kbd_valid, kbd_data, keys[i]);
            end
            do_ack();
        end
        checks++;
        if (kbd_valid !== 1'b0) begin
            errors++;
            $display("FAIL fifo_order_empty: got valid=%b want 0", kbd_valid);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) begin
            do_strobe(2'b10, 8'(i));
            if (i == 8) begin
                checks++;
                if (fifo_full !== 1'b1 || kbd_ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_full8: got full=%b ovf=%b want full=1 ovf=0", fifo_full, kbd_ovf);
                end
            end
        end
        checks++;
        if (kbd_ovf !== 1'b1 || fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set9: got ovf=%b full=%b want 1 1", kbd_ovf, fifo_full);
        end
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (kbd_valid !== 1'b1 || kbd_data !== 8'(i)) begin
                errors++;
                $display("FAIL ovf_drain_%0d: got valid=%b data=%h want valid=1 data=%h",
                         i, kbd_valid, kbd_data, 8'(i));
            end
            do_ack();
        end
        checks++;
        if (kbd_valid !== 1'b0 || kbd_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after_drain: got valid=%b ovf=%b want 0 1", kbd_valid, kbd_ovf);
        end
        do_ovf_clr();
        checks++;
        if (kbd_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: got %b want 0", kbd_ovf);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) do_strobe(2'b10, 8'hB0 + 8'(i));
        // Strobe rises here; evt is consumed on the 3rd following edge.
        @(negedge clk);
        kbd_mouse_type = 2'b10; kbd_mouse_data = 8'hAA; kbd_mouse_strobe = 1'b1;
        @(negedge clk);
        @(negedge clk); kbd_ack = 1'b1;
        @(negedge clk); kbd_ack = 1'b0;
        @(negedge clk);
        kbd_mouse_strobe = 1'b0;
        repeat (3) @(negedge clk);
        void'(m_q.pop_front());
        m_q.push_back(8'hAA);
        checks++;
        if (kbd_ovf !== 1'b0 || fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop: got ovf=%b full=%b want ovf=0 full=1", kbd_ovf, fifo_full);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (kbd_valid !== 1'b1 || kbd_data !== m_q[0]) begin
                errors++;
                $display("FAIL full_push_pop_drain_%0d: got valid=%b data=%h want valid=1 data=%h",
                         i, kbd_valid, kbd_data, m_q[0]);
            end
            if (i == DEPTH - 1) begin
                checks++;
                if (kbd_data !== 8'hAA) begin
                    errors++;
                    $display("FAIL full_push_pop_last: got %h want aa", kbd_data);
                end
            end
            do_ack();
        end
    endtask

    task automatic test_buttons();
        logic [2:0] prev;
        logic [2:0] nxt;
        for (int i = 0; i < 4; i++) begin
            prev = mouse_buttons;
            nxt = 3'($urandom_range(0, 7));
            if (nxt == prev) nxt = ~prev;
            @(negedge clk); mouse_buttons = nxt;
            @(negedge clk);
            checks++;
            if (mouse_btn !== prev) begin
                errors++;
                $display("FAIL btn_early_%0d: got %b want %b", i, mouse_btn, prev);
            end
            @(negedge clk);
            checks++;
            if (mouse_btn !== nxt) begin
                errors++;
                $display("FAIL btn_late_%0d: got %b want %b", i, mouse_btn, nxt);
            end
        end
    endtask

    task automatic test_random();
        int op;
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 8));
            if (op <= 5) do_strobe(2'($urandom_range(0, 3)), 8'($urandom));
            else if (op <= 7) do_ack();
            else do_ovf_clr();
            checks++;
            if (mouse_x !== m_x || mouse_y !== m_y || kbd_ovf !== m_ovf ||
                kbd_valid !== (m_q.size() > 0) || fifo_full !== (m_q.size() == DEPTH)) begin
                errors++;
                $display("FAIL random_%0d: got x=%h y=%h ovf=%b valid=%b full=%b want x=%h y=%h ovf=%b n=%0d",
                         i, mouse_x, mouse_y, kbd_ovf, kbd_valid, fifo_full, m_x, m_y, m_ovf, m_q.size());
            end
            if (m_q.size() > 0) begin
                checks++;
                if (kbd_data !== m_q[0]) begin
                    errors++;
                    $display("FAIL random_head_%0d: got %h want %h", i, kbd_data, m_q[0]);
                end
            end
        end
        while (m_q.size() > 0) do_ack();
    endtask

    task automatic test_reset_mid();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        do_strobe(2'b00, 8'h10);
        for (int i = 0; i < 3; i++) do_strobe(2'b10, 8'h20 + 8'(i));
        checks++;
        if (mouse_x !== 8'h10 || kbd_valid !== 1'b1 || kbd_data !== 8'h20) begin
            errors++;
            $display("FAIL reset_mid_setup: got x=%h valid=%b data=%h want 10 1 20", mouse_x, kbd_valid, kbd_data);
        end
        @(negedge clk);
        kbd_mouse_type = 2'b10; kbd_mouse_data = 8'h77; kbd_mouse_strobe = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({kbd_data, kbd_valid, mouse_x, mouse_y, fifo_full, kbd_ovf} !== 27'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got data=%h valid=%b x=%h y=%h full=%b ovf=%b want all 0",
                     kbd_data, kbd_valid, mouse_x, mouse_y, fifo_full, kbd_ovf);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (kbd_valid !== 1'b0 || mouse_x !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_no_evt: got valid=%b x=%h want 0 00", kbd_valid, mouse_x);
        end
        kbd_mouse_strobe = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) do_strobe(2'b11, 8'($urandom));
        checks++;
        if (kbd_valid !== 1'b0 || mouse_x !== 8'h00 || mouse_y !== 8'h00 || kbd_ovf !== 1'b0) begin
            errors++;
            $display("FAIL type11_ignored: got valid=%b x=%h y=%h ovf=%b want 0 00 00 0",
                     kbd_valid, mouse_x, mouse_y, kbd_ovf);
        end
        do_strobe(2'b10, 8'h5A);
        checks++;
        if (kbd_valid !== 1'b1 || kbd_data !== 8'h5A) begin
            errors++;
            $display("FAIL reset_mid_recover: got valid=%b data=%h want 1 5a", kbd_valid, kbd_data);
        end
    endtask

    initial begin
        test_reset();
        test_mouse_x();
        test_mouse_y_wrap();
        test_fifo_order();
        test_overflow();
        test_full_push_pop();
        test_buttons();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
